ibus_cksyn_div: RTL and testbench

Parametrised, single-clock successor to the bus clock-sync generator. It produces per-channel `sync` strobes that mark the rising edges of NCH derived bus clocks, each at a programmable integer ratio of the main clock. Ratios are fixed by register rather than by toggle detection. It sits in the main clock domain and feeds bus interface units that qualify transfers on `sync`. It adds the following to its predecessor:
- a lookahead strobe
- glitch-free runtime ratio changes
- phase readback
- a cross-channel phase align

---
 rtl/ibus_cksyn_div_if.sv | 17 +
 rtl/ibus_cksyn_div.sv | 97 +++++++++
 tb/tb_ibus_cksyn_div.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/ibus_cksyn_div_if.sv
// Bus bundle for the sync-strobe divider: control from the host side, strobes
// and phase readback towards the bus interface units.
interface ibus_cksyn_div_if #(
  parameter int NCH = 2,
  parameter int RW  = 4
);
  logic [NCH-1:0]    en;
  logic [NCH*RW-1:0] ratio;
  logic              align;
  logic [NCH-1:0]    sync;
  logic [NCH-1:0]    sync_pre;
  logic [NCH*RW-1:0] phase;
  logic [NCH-1:0]    ratio_ack;

  modport master (output en, ratio, align, input sync, sync_pre, phase, ratio_ack);
  modport slave  (input en, ratio, align, output sync, sync_pre, phase, ratio_ack);
endinterface

// File: rtl/ibus_cksyn_div.sv
// NCH independent integer clock dividers that emit a sync strobe (plus a
// one-cycle lookahead) on the last main-clock cycle of each derived period.
module ibus_cksyn_div_ch #(
  parameter int RW = 4
) (
  input  logic          clk_ungated,
  input  logic          rst_a,
  input  logic          en,
  input  logic          align,
  input  logic [RW-1:0] ratio,
  output logic          sync,
  output logic          sync_pre,
  output logic          ratio_ack,
  output logic [RW-1:0] phase
);
  localparam logic [RW-1:0] ONE = RW'(1);

  logic [RW-1:0] cnt, act, cnt_nxt, act_nxt;
  logic [RW-1:0] eff, last, rat_eff;
  logic          en_q, ack_nxt, start, wrap;

  assign eff     = (act == '0) ? ONE : act;
  assign rat_eff = (ratio == '0) ? ONE : ratio;
  assign last    = eff - ONE;
  assign start   = en & ~en_q;
  assign wrap    = (cnt == last);

  // act only moves when cnt returns to 0, so cnt never exceeds last
  always_comb begin
    cnt_nxt = cnt;
    act_nxt = act;
    ack_nxt = 1'b0;
    if (!en || start) begin
      cnt_nxt = '0;
      act_nxt = ratio;
    end else if (align || wrap) begin
      cnt_nxt = '0;
      act_nxt = ratio;
      ack_nxt = (rat_eff != eff);
    end else begin
      cnt_nxt = cnt + ONE;
    end
  end

  always_ff @(posedge clk_ungated or negedge rst_a) begin
    if (!rst_a) begin
      cnt       <= '0;
      act       <= ONE;
      en_q      <= 1'b0;
      ratio_ack <= 1'b0;
    end else begin
      cnt       <= cnt_nxt;
      act       <= act_nxt;
      en_q      <= en;
      ratio_ack <= ack_nxt;
    end
  end

  // Strobes decode straight from flops; no input reaches an output unregistered
  assign sync     = en_q & wrap;
  assign sync_pre = en_q & ((eff == ONE) ? 1'b1 : (cnt == last - ONE));
  assign phase    = cnt;
endmodule

module ibus_cksyn_div #(
  parameter int NCH = 2,
  parameter int RW  = 4
) (
  input  logic                 clk_ungated,
  input  logic                 rst_a,
  ibus_cksyn_div_if.slave      bus
);
  logic [NCH-1:0]         sync, sync_pre, ratio_ack;
  logic [NCH-1:0][RW-1:0] phase;
  logic [NCH-1:0][RW-1:0] ratio;

  assign ratio = bus.ratio;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    ibus_cksyn_div_ch #(.RW(RW)) u_ch (
      .clk_ungated (clk_ungated),
      .rst_a       (rst_a),
      .en          (bus.en[i]),
      .align       (bus.align),
      .ratio       (ratio[i]),
      .sync        (sync[i]),
      .sync_pre    (sync_pre[i]),
      .ratio_ack   (ratio_ack[i]),
      .phase       (phase[i])
    );
  end

  assign bus.sync      = sync;
  assign bus.sync_pre  = sync_pre;
  assign bus.ratio_ack = ratio_ack;
  assign bus.phase     = phase;
endmodule

// File: tb/tb_ibus_cksyn_div.sv
// Self-checking bench: directed table, hand-written corner sequences and a
// randomized run, all cross-checked against a period/position reference model.
module tb_ibus_cksyn_div;
  localparam int NCH = 2;
  localparam int RW  = 4;

  logic clk_ungated = 1'b0;
  logic rst_a;
  int   tests = 0;
  int   fails = 0;

  ibus_cksyn_div_if #(.NCH(NCH), .RW(RW)) bus ();
  ibus_cksyn_div #(.NCH(NCH), .RW(RW)) dut (
    .clk_ungated (clk_ungated),
    .rst_a       (rst_a),
    .bus         (bus)
  );

  always #5 clk_ungated = ~clk_ungated;

  // Reference model: each channel is a period length and a position in it
  int m_pos [NCH];
  int m_per [NCH];
  bit m_enq [NCH];
  bit m_ack [NCH];

  function automatic int norm(int r);
    return (r == 0) ? 1 : r;
  endfunction

  function automatic int ratio_of(int ch);
    logic [RW-1:0] r;
    r = bus.ratio[ch*RW +: RW];
    return int'(r);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_pos[i] = 0; m_per[i] = 1; m_enq[i] = 0; m_ack[i] = 0;
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < NCH; i++) begin
      int r;
      r = norm(ratio_of(i));
      m_ack[i] = 0;
      if (!bus.en[i] || !m_enq[i]) begin
        m_pos[i] = 0; m_per[i] = r;
      end else if (bus.align || m_pos[i] == m_per[i] - 1) begin
        m_ack[i] = (r != m_per[i]);
        m_pos[i] = 0; m_per[i] = r;
      end else begin
        m_pos[i] = m_pos[i] + 1;
      end
      m_enq[i] = bus.en[i];
    end
  endtask

  task automatic cmp(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int dut_phase(int ch);
    logic [RW-1:0] p;
    p = bus.phase[ch*RW +: RW];
    return int'(p);
  endfunction

  task automatic check_model();
    for (int i = 0; i < NCH; i++) begin
      bit es, ep;
      es = m_enq[i] && (m_pos[i] == m_per[i] - 1);
      ep = m_enq[i] && (m_per[i] == 1 || m_pos[i] == m_per[i] - 2);
      cmp($sformatf("model sync[%0d]", i),      int'(bus.sync[i]),      int'(es));
      cmp($sformatf("model sync_pre[%0d]", i),  int'(bus.sync_pre[i]),  int'(ep));
      cmp($sformatf("model phase[%0d]", i),     dut_phase(i),           m_pos[i]);
      cmp($sformatf("model ratio_ack[%0d]", i), int'(bus.ratio_ack[i]), int'(m_ack[i]));
    end
  endtask

  task automatic step();
    @(posedge clk_ungated);
    model_edge();
    #1;
    check_model();
  endtask

  task automatic set_ch(int ch, bit e, int r);
    bus.en[ch] = e;
    bus.ratio[ch*RW +: RW] = RW'(r);
  endtask

  typedef struct {
    bit en; int ratio; bit align;
    bit s;  bit p;     int ph; bit ack;
  } vec_t;
  vec_t tbl [18];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    // ch0: ratio 3 start-up, 3->5 mid-period change, then 0/1 handling, then off
    tbl[0]  = '{1, 3, 0, 0, 0, 0, 0};
    tbl[1]  = '{1, 3, 0, 0, 1, 1, 0};
    tbl[2]  = '{1, 3, 0, 1, 0, 2, 0};
    tbl[3]  = '{1, 3, 0, 0, 0, 0, 0};
    tbl[4]  = '{1, 3, 0, 0, 1, 1, 0};
    tbl[5]  = '{1, 3, 0, 1, 0, 2, 0};
    tbl[6]  = '{1, 3, 0, 0, 0, 0, 0};
    tbl[7]  = '{1, 3, 0, 0, 1, 1, 0};
    tbl[8]  = '{1, 5, 0, 1, 0, 2, 0};
    tbl[9]  = '{1, 5, 0, 0, 0, 0, 1};
    tbl[10] = '{1, 5, 0, 0, 0, 1, 0};
    tbl[11] = '{1, 5, 0, 0, 0, 2, 0};
    tbl[12] = '{1, 5, 0, 0, 1, 3, 0};
    tbl[13] = '{1, 5, 0, 1, 0, 4, 0};
    tbl[14] = '{1, 0, 0, 1, 1, 0, 1};
    tbl[15] = '{1, 1, 0, 1, 1, 0, 0};
    tbl[16] = '{1, 0, 0, 1, 1, 0, 0};
    tbl[17] = '{0, 0, 0, 0, 0, 0, 0};

    rst_a = 1'b0;
    bus.en = '0; bus.ratio = '0; bus.align = 1'b0;
    model_reset();
    #12;
    cmp("reset sync",      int'(bus.sync),      0);
    cmp("reset sync_pre",  int'(bus.sync_pre),  0);
    cmp("reset phase",     int'(bus.phase),     0);
    cmp("reset ratio_ack", int'(bus.ratio_ack), 0);
    rst_a = 1'b1;

    set_ch(1, 0, 2);
    for (int k = 0; k < 18; k++) begin
      set_ch(0, tbl[k].en, tbl[k].ratio);
      bus.align = tbl[k].align;
      step();
      cmp($sformatf("tbl%0d sync", k),  int'(bus.sync[0]),      int'(tbl[k].s));
      cmp($sformatf("tbl%0d pre", k),   int'(bus.sync_pre[0]),  int'(tbl[k].p));
      cmp($sformatf("tbl%0d phase", k), dut_phase(0),           tbl[k].ph);
      cmp($sformatf("tbl%0d ack", k),   int'(bus.ratio_ack[0]), int'(tbl[k].ack));
    end

    // Align while ch0 sits on its wrap cycle and ch1 is mid-period
    set_ch(0, 1, 4); set_ch(1, 1, 6);
    for (int k = 0; k < 4; k++) step();
    bus.align = 1'b1;
    step();
    bus.align = 1'b0;
    cmp("align ph0", dut_phase(0), 0);
    cmp("align ph1", dut_phase(1), 0);
    cmp("align ack0", int'(bus.ratio_ack[0]), 0);
    for (int k = 1; k <= 5; k++) begin
      step();
      cmp($sformatf("align+%0d sync0", k), int'(bus.sync[0]), int'(k == 3));
      cmp($sformatf("align+%0d sync1", k), int'(bus.sync[1]), int'(k == 5));
    end

    // en drop at phase 2 with ratio 4, then restart
    set_ch(0, 0, 4); set_ch(1, 0, 6);
    step();
    set_ch(0, 1, 4);
    for (int k = 0; k < 3; k++) step();
    cmp("drop pre-phase", dut_phase(0), 2);
    set_ch(0, 0, 4);
    step();
    cmp("drop sync",  int'(bus.sync[0]),     0);
    cmp("drop pre",   int'(bus.sync_pre[0]), 0);
    cmp("drop phase", dut_phase(0),          0);
    set_ch(0, 1, 4);
    for (int k = 0; k < 4; k++) begin
      step();
      cmp($sformatf("restart%0d sync", k), int'(bus.sync[0]), int'(k == 3));
    end

    // Asynchronous reset mid-period, ratio 5
    set_ch(0, 1, 5);
    for (int k = 0; k < 3; k++) step();
    #2 rst_a = 1'b0;
    #1;
    model_reset();
    cmp("arst sync",      int'(bus.sync),      0);
    cmp("arst sync_pre",  int'(bus.sync_pre),  0);
    cmp("arst phase",     int'(bus.phase),     0);
    cmp("arst ratio_ack", int'(bus.ratio_ack), 0);
    #3 rst_a = 1'b1;
    n = 0;
    do begin
      step();
      n++;
    end while (!bus.sync[0] && n < 12);
    cmp("arst first sync edges", n, 5);

    // Randomized run against the model
    for (int k = 0; k < 600; k++) begin
      for (int i = 0; i < NCH; i++) begin
        if ($urandom_range(0, 19) == 0) bus.en[i] = ~bus.en[i];
        if ($urandom_range(0, 7) == 0)  bus.ratio[i*RW +: RW] = RW'($urandom_range(0, 7));
      end
      bus.align = ($urandom_range(0, 24) == 0);
      step();
    end
    bus.align = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
